// File: rtl/uart_rx_ctrl.sv
// Oversampled UART receiver: 2-flop line synchronizer, framing FSM and a one-word holding register.
// Define UART_RX_PARITY_EN to compile in the parity bit check and the parity_odd port.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 rx_en,
  input  logic                 baud_tick,
  input  logic                 uart_rxd,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
`endif
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_p0;
  logic                   sync_p0;
  logic                   rxd_s;
  logic                   rxd_s_p1;
  logic                   par_bad;
  logic                   mid_sample;
  logic                   start_sample;
  logic                   load;

`ifdef UART_RX_PARITY_EN
  // Even parity: data plus parity bit carry an even count of ones; odd parity: an odd count.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] word,
                                           input logic pbit, input logic odd);
    return (^word ^ pbit) != odd;
  endfunction
`endif

  // Stage p0/p1: metastability synchronizer plus one-cycle history for falling-edge detect
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      sync_p0  <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_s_p1 <= 1'b1;
    end else begin
      sync_p0  <= uart_rxd;
      rxd_s    <= sync_p0;
      rxd_s_p1 <= rxd_s;
    end
  end

  assign start_sample = baud_tick && (tick_cnt == TICK_HALF);
  assign mid_sample   = baud_tick && (tick_cnt == TICK_LAST);
  assign load         = rx_en && (state == STOP) && mid_sample && rxd_s && !par_bad;

  // Framing FSM: counts oversample ticks and shifts data LSB first
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_p0  <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if ((state != IDLE) && !rx_en) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_en && rxd_s_p1 && !rxd_s) begin
              state    <= START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end
          START: begin
            if (start_sample) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
              par_bad  <= 1'b0;
`endif
              if (!rxd_s) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else if (baud_tick) begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (mid_sample) begin
              tick_cnt <= '0;
              shift_p0 <= {rxd_s, shift_p0[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else if (baud_tick) begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (mid_sample) begin
              tick_cnt   <= '0;
              par_bad    <= parity_mismatch(shift_p0, rxd_s, parity_odd);
              parity_err <= parity_mismatch(shift_p0, rxd_s, parity_odd);
              state      <= STOP;
            end else if (baud_tick) begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`endif
          STOP: begin
            if (mid_sample) begin
              tick_cnt <= '0;
              state    <= IDLE;
              busy     <= 1'b0;
              // A frame already flagged for parity reports nothing further
              if (!rxd_s && !par_bad) frame_err <= 1'b1;
            end else if (baud_tick) begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Stage p1: holding register; a load in a consuming cycle replaces the old word
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (load) begin
        if (rx_valid && !rx_ready) begin
          overrun_err <= 1'b1;
        end else begin
          rx_data  <= shift_p0;
          rx_valid <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are serialised bit by bit and expected outcomes queued.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  localparam int DB = 8;
  localparam int OS = 16;

  logic          pclk      = 1'b0;
  logic          preset    = 1'b1;
  logic          rx_en     = 1'b0;
  logic          baud_tick = 1'b0;
  logic          uart_rxd  = 1'b1;
  logic          rx_ready  = 1'b1;
`ifdef UART_RX_PARITY_EN
  logic          parity_odd = 1'b0;
`endif
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun_err;
  logic          busy;

  uart_rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .rx_en       (rx_en),
    .baud_tick   (baud_tick),
    .uart_rxd    (uart_rxd),
`ifdef UART_RX_PARITY_EN
    .parity_odd  (parity_odd),
`endif
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 pclk = ~pclk;

  typedef enum int {EV_DATA, EV_FRAME, EV_PARITY, EV_OVERRUN} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [DB-1:0] data;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   held   = 1'b0;   // reference: an unconsumed word sits in the output register
  bit   dense  = 1'b1;   // baud_tick every cycle when set, sparse random ticks otherwise
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [DB-1:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event got kind %0d data %0h want none", k, d);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    if (k == EV_DATA && e.kind == EV_DATA) check("rx_data", d, e.data);
  endtask

  // Monitor: a new word is visible when rx_valid rises or stays high after a consuming cycle
  always @(negedge pclk) begin
    if (!preset) begin
      if (rx_valid && (!prev_valid || prev_ready)) expect_ev(EV_DATA, rx_data);
      if (frame_err)   expect_ev(EV_FRAME, '0);
      if (parity_err)  expect_ev(EV_PARITY, '0);
      if (overrun_err) expect_ev(EV_OVERRUN, '0);
    end
    prev_valid = rx_valid;
    prev_ready = rx_ready;
  end

  task automatic step();
    @(posedge pclk);
    #1;
    baud_tick = dense ? 1'b1 : ($urandom_range(0, 2) != 0);
  endtask

  task automatic line_ticks(input logic b, input int n);
    int c;
    c = 0;
    uart_rxd = b;
    while (c < n) begin
      step();
      if (baud_tick) c++;
    end
  endtask

  function automatic logic good_par(input logic [DB-1:0] d);
`ifdef UART_RX_PARITY_EN
    return logic'(($countones(d) % 2) != 0) ^ parity_odd;
`else
    return 1'b0;
`endif
  endfunction

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
    ev_t e;
    bit  par_bad;
    par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad = ((($countones(d) + int'(par_b)) % 2) != int'(parity_odd));
`endif
    e.data = d;
    if (par_bad)      e.kind = EV_PARITY;
    else if (!stop_b) e.kind = EV_FRAME;
    else if (held)    e.kind = EV_OVERRUN;
    else begin
      e.kind = EV_DATA;
      if (!rx_ready) held = 1'b1;
    end
    exp_q.push_back(e);
    line_ticks(1'b0, OS);
    for (int i = 0; i < DB; i++) line_ticks(d[i], OS);
`ifdef UART_RX_PARITY_EN
    line_ticks(par_b, OS);
`else
    if (par_b) uart_rxd = 1'b1;
`endif
    line_ticks(stop_b, OS);
    line_ticks(1'b1, OS + int'($urandom_range(0, 8)));
  endtask

  task automatic send_partial(input logic [DB-1:0] d, input int nbits, input int extra);
    line_ticks(1'b0, OS);
    for (int i = 0; i < nbits; i++) line_ticks(d[i], OS);
    line_ticks(d[nbits], extra);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DB-1:0] d;
    logic sb;

    repeat (3) @(posedge pclk);
    #1;
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_overrun_err", overrun_err, 0);
    preset = 1'b0;
    rx_en  = 1'b1;
    line_ticks(1'b1, 4);

    send_frame(8'hA5, 1'b1, good_par(8'hA5));

    // Start glitch shorter than half a bit
    line_ticks(1'b0, 4);
    check("glitch_busy_set", busy, 1);
    uart_rxd = 1'b1;
    n = 0;
    while (busy && n < 30) begin
      step();
      n++;
    end
    check("glitch_busy_clear", (n <= 10), 1);
    line_ticks(1'b1, OS);

    send_frame(8'h3C, 1'b0, good_par(8'h3C));
    line_ticks(1'b1, OS);
    send_frame(8'h3C, 1'b1, good_par(8'h3C));

    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, good_par(8'h11));
    send_frame(8'h22, 1'b1, good_par(8'h22));
    check("overrun_hold_data", rx_data, 8'h11);
    check("overrun_hold_valid", rx_valid, 1);

    // Asynchronous reset in the middle of a frame
    send_partial(8'h6B, 3, 5);
    preset   = 1'b1;
    uart_rxd = 1'b1;
    #2;
    check("midreset_busy", busy, 0);
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_rx_data", rx_data, 0);
    step();
    preset   = 1'b0;
    held     = 1'b0;
    rx_ready = 1'b1;
    line_ticks(1'b1, 2 * OS);

    // Receiver disabled during data bit 3
    send_partial(8'h5A, 3, OS / 2);
    rx_en = 1'b0;
    step();
    check("en_drop_busy", busy, 0);
    line_ticks(1'b1, 2 * OS);
    rx_en = 1'b1;
    line_ticks(1'b1, 4);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 24; i++) begin
      dense    = ($urandom_range(0, 1) != 0);
      d        = DB'($urandom);
      sb       = ($urandom_range(0, 4) != 0);
      rx_ready = ($urandom_range(0, 3) != 0);
      if (rx_ready) held = 1'b0;
      send_frame(d, sb, good_par(d) ^ ($urandom_range(0, 4) == 0));
    end

    dense    = 1'b1;
    rx_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    repeat (4) step();
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
